// File: rtl/audio_pll_lock_controller.sv
// rtl/audio_pll_lock_controller.sv - audio PLL reset sequencing, lock qualification and retry supervision
module audio_pll_lock_controller #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int LOCK_STABLE      = 1024,
    parameter int MAX_RETRIES      = 3,
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic            refclk,
    input  logic            rst,
    input  logic            pll_locked,
    input  logic            relock_req,
    output logic            pll_rst,
    output logic            audio_rst,
    output logic            ready,
    output logic            fault,
    output logic            lock_lost,
    output logic [RC_W-1:0] retry_count
);

    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RC_W-1:0]  RC_MAX       = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [RC_W-1:0]  retry_d;
    logic             lost_d;
    logic             sync_ff1;
    logic             lock_s;
    logic             cnt_run;

    // pll_locked comes from the audio PLL domain; only lock_s is trusted
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            lock_s   <= 1'b0;
        end else begin
            sync_ff1 <= pll_locked;
            lock_s   <= sync_ff1;
        end
    end

    always_comb begin
        state_d = state;
        retry_d = retry_count;
        lost_d  = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // lock is checked first so it wins on the timeout cycle
                if (lock_s) begin
                    state_d = S_STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count < RC_MAX) begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_count + 1'b1;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_STABILIZE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    lost_d  = 1'b1;
                    state_d = S_RESET_PLL;
                end else if (relock_req) begin
                    state_d = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                if (relock_req) begin
                    state_d = S_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase
    end

    // RUN and FAULT have no time limit, so the counter simply holds there
    assign cnt_run = (state == S_RESET_PLL) || (state == S_WAIT_LOCK) || (state == S_STABILIZE);

    // outputs are registered from the next state so they never glitch
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            audio_rst   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_d;
            retry_count <= retry_d;
            lock_lost   <= lost_d;
            pll_rst     <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
            audio_rst   <= (state_d != S_RUN);
            ready       <= (state_d == S_RUN);
            fault       <= (state_d == S_FAULT);
            if (state_d != state) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
